// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and state encoding for the SRAM sequencer
// Purpose: bus/word/address widths, idle pin levels and the FSM state enum
//          used by sram_ctrl. No ports.
package sram_pkg;

   localparam int ADDR_W = 11;   // SRAM word address width
   localparam int BUS_W  = 32;   // SRAM data bus width
   localparam int WORD_W = 16;   // stored word width

   // Pin levels held whenever no access is in flight
   localparam logic NOE_IDLE  = 1'b1;
   localparam logic READ_IDLE = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RADDR   = 3'd1,
      S_RDATA   = 3'd2,
      S_WADDR   = 3'd3,
      S_WSTROBE = 3'd4,
      S_TURN    = 3'd5
   } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - request sequencer driving the 2K x 16 SRAM pin protocol
// Purpose: accepts one valid/ready request at a time and sequences it onto
//          the SRAM pins (adrx, tristate data, nOE, read), returning read data
//          with a one-cycle rsp_valid pulse. Three cycles per access.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we/addr/wdata     request fields, registered on accept
//   rsp_valid/rsp_rdata   completion pulse and read data (0 for writes)
//   adrx, data, nOE, read SRAM address, tristate bus, output enable, strobe
// Option: SRAM_CTRL_TURNAROUND_EN inserts one idle S_TURN cycle between a
//         read and a following write.
module sram_ctrl
   import sram_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] adrx,
   inout  wire  [BUS_W-1:0]  data,
   output logic              nOE,
   output logic              read
);

   state_t              r_state;
   logic                r_ready;
   logic                r_rsp_valid;
   logic [WORD_W-1:0]   r_rdata;
   logic [ADDR_W-1:0]   r_adrx;
   logic                r_noe;
   logic                r_read;
   logic                r_drive;
   logic [WORD_W-1:0]   r_wdata;
`ifdef SRAM_CTRL_TURNAROUND_EN
   logic                r_last_rd;   // previous accepted access was a read
   logic [ADDR_W-1:0]   r_addr;      // write address parked during S_TURN
`endif

   // Only the low word of the bus carries stored data
   logic [WORD_W-1:0]   w_bus_lo;
   assign w_bus_lo = data[WORD_W-1:0];

   // Bus is driven only while in S_WADDR; r_drive is never set with nOE low
   assign data = r_drive ? {{(BUS_W-WORD_W){1'b0}}, r_wdata} : {BUS_W{1'bz}};

   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign adrx      = r_adrx;
   assign nOE       = r_noe;
   assign read      = r_read;

   // All pin levels are registered at entry to the state that needs them,
   // so each state's outputs are valid for its whole cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_adrx      <= '0;
         r_noe       <= NOE_IDLE;
         r_read      <= READ_IDLE;
         r_drive     <= 1'b0;
         r_wdata     <= '0;
`ifdef SRAM_CTRL_TURNAROUND_EN
         r_last_rd   <= 1'b0;
         r_addr      <= '0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_ready) begin
                  r_ready <= 1'b0;
                  r_wdata <= req_wdata;
                  if (!req_we) begin
                     r_adrx  <= req_addr;
                     r_state <= S_RADDR;
`ifdef SRAM_CTRL_TURNAROUND_EN
                     r_last_rd <= 1'b1;
`endif
                  end else begin
`ifdef SRAM_CTRL_TURNAROUND_EN
                     r_last_rd <= 1'b0;
                     r_addr    <= req_addr;
                     if (r_last_rd) begin
                        r_state <= S_TURN;
                     end else begin
                        r_adrx  <= req_addr;
                        r_read  <= 1'b0;
                        r_drive <= 1'b1;
                        r_state <= S_WADDR;
                     end
`else
                     r_adrx  <= req_addr;
                     r_read  <= 1'b0;
                     r_drive <= 1'b1;
                     r_state <= S_WADDR;
`endif
                  end
               end
            end
            S_RADDR: begin
               r_noe   <= 1'b0;
               r_state <= S_RDATA;
            end
            S_RDATA: begin
               r_rdata     <= w_bus_lo;
               r_rsp_valid <= 1'b1;
               r_noe       <= NOE_IDLE;
               r_ready     <= 1'b1;
               r_state     <= S_IDLE;
            end
            S_WADDR: begin
               // Rising edge of read here commits MDR into mem[MAR]
               r_read  <= READ_IDLE;
               r_drive <= 1'b0;
               r_state <= S_WSTROBE;
            end
            S_WSTROBE: begin
               r_rdata     <= '0;
               r_rsp_valid <= 1'b1;
               r_ready     <= 1'b1;
               r_state     <= S_IDLE;
            end
`ifdef SRAM_CTRL_TURNAROUND_EN
            S_TURN: begin
               r_adrx  <= r_addr;
               r_read  <= 1'b0;
               r_drive <= 1'b1;
               r_state <= S_WADDR;
            end
`endif
            default: begin
               r_noe   <= NOE_IDLE;
               r_read  <= READ_IDLE;
               r_drive <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
